// File: rtl/iomem_dma_pkg.sv
// Shared definitions for the iomem word-copy engine: register map, CTRL bit
// positions, FSM states and master strobe encodings.
package iomem_dma_pkg;

  localparam logic [3:0] REG_SRC  = 4'h0;
  localparam logic [3:0] REG_DST  = 4'h4;
  localparam logic [3:0] REG_CNT  = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_SRC_INC = 3;
  localparam int CTRL_DST_INC = 4;
  localparam int CTRL_ABORT   = 5;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Merge a byte-strobed write into an existing 32-bit value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_dma_regs.sv
// Responder register file for the copy engine. Holds the SRC/DST/COUNT
// working registers (advanced by the engine after each write beat), the CTRL
// flags, and decodes the START/ABORT pulses from CPU writes.
module iomem_dma_regs
  import iomem_dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_sel,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_wstrb,
  input  logic [3:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             busy,
  input  logic             advance,
  input  logic             fin,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [CNT_W-1:0] cnt,
  output logic             src_inc,
  output logic             dst_inc,
  output logic             start,
  output logic             abort
);

  logic        acc;
  logic        wr_en;
  logic        ctrl_wr;
  logic        done_clr;
  logic        done;
  logic [31:0] ctrl_rd;
  logic [31:0] rd_mux;

  // A new access is accepted only when ready is low, so ready never
  // asserts on two consecutive cycles.
  assign acc      = cfg_sel & ~cfg_ready;
  assign wr_en    = acc & (|cfg_wstrb);
  assign ctrl_wr  = wr_en & (cfg_addr == REG_CTRL) & cfg_wstrb[0];
  assign start    = ctrl_wr & cfg_wdata[CTRL_START];
  assign abort    = ctrl_wr & cfg_wdata[CTRL_ABORT];
  assign done_clr = ctrl_wr & cfg_wdata[CTRL_DONE];

  // CTRL readback image; START and ABORT are pulses and read as 0.
  always_comb begin
    ctrl_rd               = 32'h0;
    ctrl_rd[CTRL_BUSY]    = busy;
    ctrl_rd[CTRL_DONE]    = done;
    ctrl_rd[CTRL_SRC_INC] = src_inc;
    ctrl_rd[CTRL_DST_INC] = dst_inc;
  end

  // Read data mux over the live working registers.
  always_comb begin
    rd_mux = 32'h0;
    case (cfg_addr)
      REG_SRC:  rd_mux = src;
      REG_DST:  rd_mux = dst;
      REG_CNT:  rd_mux = 32'(cnt);
      REG_CTRL: rd_mux = ctrl_rd;
      default:  rd_mux = 32'h0;
    endcase
  end

  // Register-port handshake: one-cycle ready with registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      cfg_rdata <= 32'h0;
    end else begin
      cfg_ready <= acc;
      if (acc) cfg_rdata <= rd_mux;
    end
  end

  // Working registers: engine advance has priority; CPU writes land only when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      src     <= 32'h0;
      dst     <= 32'h0;
      cnt     <= '0;
      src_inc <= 1'b1;
      dst_inc <= 1'b1;
    end else if (advance) begin
      if (src_inc) src <= src + 32'd4;
      if (dst_inc) dst <= dst + 32'd4;
      cnt <= cnt - CNT_W'(1);
    end else if (wr_en && !busy) begin
      case (cfg_addr)
        REG_SRC: src <= merge_bytes(src, cfg_wdata, cfg_wstrb) & 32'hFFFF_FFFC;
        REG_DST: dst <= merge_bytes(dst, cfg_wdata, cfg_wstrb) & 32'hFFFF_FFFC;
        REG_CNT: cnt <= CNT_W'(merge_bytes(32'(cnt), cfg_wdata, cfg_wstrb));
        REG_CTRL: begin
          if (cfg_wstrb[0]) begin
            src_inc <= cfg_wdata[CTRL_SRC_INC];
            dst_inc <= cfg_wdata[CTRL_DST_INC];
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky DONE flag: completion sets it and wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (fin) begin
      done <= 1'b1;
    end else if (done_clr) begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/iomem_dma.sv
// iomem word-copy engine: alternates a read beat from SRC and a write beat to
// DST on the iomem master port until COUNT reaches zero or an abort lands.
module iomem_dma
  import iomem_dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_sel,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_wstrb,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  state_e           state;
  state_e           state_nx;
  logic             gap;
  logic             abort_pend;
  logic             abort_now;
  logic [31:0]      rbuf;
  logic             busy;
  logic             fin;
  logic             hs;
  logic             advance;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [CNT_W-1:0] cnt;
  logic             src_inc;
  logic             dst_inc;
  logic             start;
  logic             abort;

  iomem_dma_regs #(.CNT_W(CNT_W)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .cfg_sel   (cfg_sel),
    .cfg_ready (cfg_ready),
    .cfg_wstrb (cfg_wstrb),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .busy      (busy),
    .advance   (advance),
    .fin       (fin),
    .src       (src),
    .dst       (dst),
    .cnt       (cnt),
    .src_inc   (src_inc),
    .dst_inc   (dst_inc),
    .start     (start),
    .abort     (abort)
  );

  assign busy      = (state == ST_RD) || (state == ST_WR);
  assign fin       = (state == ST_FIN);
  assign hs        = m_valid & m_ready;
  assign advance   = (state == ST_WR) & hs;
  assign abort_now = abort_pend | abort;

  // State register; gap forces one idle bus cycle after every accepted beat,
  // and a pending abort is remembered only while a transfer is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gap        <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      gap        <= hs;
      abort_pend <= busy & abort_now;
    end
  end

  // Read-beat data buffer, replayed on the following write beat.
  always_ff @(posedge clk) begin
    if ((state == ST_RD) && hs) rbuf <= m_rdata;
  end

  // Next-state logic; an in-flight beat always completes before FIN.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = (cnt != '0) ? ST_RD : ST_FIN;
      end
      ST_RD: begin
        if (hs) state_nx = abort_now ? ST_FIN : ST_WR;
      end
      ST_WR: begin
        if (hs) state_nx = ((cnt == CNT_W'(1)) || abort_now) ? ST_FIN : ST_RD;
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus and interrupt outputs decoded from state; all zero when idle.
  always_comb begin
    m_valid = 1'b0;
    m_addr  = 32'h0;
    m_wstrb = WSTRB_READ;
    m_wdata = 32'h0;
    irq     = 1'b0;
    case (state)
      ST_RD: begin
        m_valid = ~gap;
        m_addr  = src;
      end
      ST_WR: begin
        m_valid = ~gap;
        m_addr  = dst;
        m_wstrb = WSTRB_WORD;
        m_wdata = rbuf;
      end
      ST_FIN:  irq = 1'b1;
      default: ;
    endcase
  end

endmodule
